multicycle_controller: RTL and testbench

Multi-cycle control FSM that sequences the shared MIPS datapath: one memory port, one ALU, the register file and an external multi-cycle floating-point unit. It handles the same instruction set as the single-cycle decoder: R-type, FP (opcode 110011), addi, lw, sw, beq and j. Per state it emits the mux selects and write enables. It also handles a memory ready handshake and an FP start/done handshake with timeout.

---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcodes
// and the datapath select codes driven by the controller.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      REXEC  = 4'd6,
      RWB    = 4'd7,
      ADDIEX = 4'd8,
      ADDIWB = 4'd9,
      BRANCH = 4'd10,
      JUMP   = 4'd11,
      FPEXEC = 4'd12,
      FPWB   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_FP    = 6'b110011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // First execute state for an opcode; FETCH marks an unsupported opcode.
   function automatic state_t decode_target(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return REXEC;
         OP_FP:        return FPEXEC;
         OP_ADDI:      return ADDIEX;
         OP_LW, OP_SW: return MEMADR;
         OP_BEQ:       return BRANCH;
         OP_J:         return JUMP;
         default:      return FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the shared MIPS datapath, with memory-ready
// and FP start/done handshakes and an FP timeout.
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int FP_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       fp_done,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       floating,
   output logic       fp_start,
   output logic       illegal_op,
   output logic       fp_timeout,
   output logic       instr_done,
   output logic [3:0] state
);

   localparam int            CW       = $clog2(FP_TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(FP_TIMEOUT - 1);

   state_t        st;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic          fp_first;

   // Branch-taken gating on zero happens in the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= FETCH;
         cnt      <= '0;
         fp_first <= 1'b0;
      end else begin
         st       <= nxt;
         fp_first <= (st == DECODE) && (nxt == FPEXEC);
         cnt      <= ((st == FPEXEC) && (nxt == FPEXEC)) ? cnt + 1'b1 : '0;
      end
   end

   // Handshakes: mem_ready and fp_done are single-cycle completion strobes.
   // They are sampled only in the states waiting on them (FETCH/MEMRD/MEMWR
   // and FPEXEC); while low, the waiting state simply holds.
   always_comb begin
      nxt         = st;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      floating    = 1'b0;
      fp_start    = 1'b0;
      illegal_op  = 1'b0;
      fp_timeout  = 1'b0;
      instr_done  = 1'b0;
      case (st)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               nxt     = DECODE;
            end
         end
         DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            nxt     = decode_target(opcode);
            if (nxt == FETCH) begin
               illegal_op = 1'b1;
               instr_done = 1'b1;
            end
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) nxt = MEMWB;
         end
         MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               nxt        = FETCH;
            end
         end
         REXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
            nxt     = RWB;
         end
         RWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = ADDIWB;
         end
         ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            instr_done  = 1'b1;
            nxt         = FETCH;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         FPEXEC: begin
            floating = 1'b1;
            ALUSrcA  = 1'b1;
            ALUOp    = ALUOP_FUNCT;
            fp_start = fp_first;
            // A result arriving on the last allowed cycle still wins.
            if (fp_done) begin
               nxt = FPWB;
            end else if (cnt == CNT_LAST) begin
               fp_timeout = 1'b1;
               instr_done = 1'b1;
               nxt        = FETCH;
            end
         end
         FPWB: begin
            floating   = 1'b1;
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            nxt        = FETCH;
         end
         default: nxt = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations from
// a latency/pulse-count model, checked by a monitor on every instr_done.
module tb_multicycle_controller;
   import mc_ctrl_pkg::*;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       fp_done = 1'b0;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic       floating, fp_start, illegal_op, fp_timeout, instr_done;
   logic [3:0] state;

   always #5 clk = ~clk;

   multicycle_controller #(.FP_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .fp_done(fp_done),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .floating(floating), .fp_start(fp_start),
      .illegal_op(illegal_op), .fp_timeout(fp_timeout),
      .instr_done(instr_done), .state(state)
   );

   typedef struct {
      int lat;
      int done_st;
      int illegal;
      int tmo;
      int regwrite;
      int memtoreg;
      int memread;
      int memwrite;
      int pcwrite;
      int pccond;
      int irwrite;
      int fpstart_n;
      int fpstart_at;
      int floating;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_issued = 0;
   int   n_done = 0;

   logic [5:0] ops [8] = '{OP_RTYPE, OP_FP, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, 6'b111111};

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor accumulators for the instruction currently in flight.
   int a_lat, a_rw, a_m2r, a_mr, a_mw, a_pcw, a_pcc, a_ir, a_fps_n, a_fps_at, a_fl, a_ill, a_tmo;

   task automatic clear_acc();
      a_lat = 0; a_rw = 0; a_m2r = 0; a_mr = 0; a_mw = 0; a_pcw = 0; a_pcc = 0;
      a_ir = 0; a_fps_n = 0; a_fps_at = 0; a_fl = 0; a_ill = 0; a_tmo = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         clear_acc();
      end else begin
         a_lat++;
         if (RegWrite) a_rw++;
         if (MemtoReg) a_m2r++;
         if (MemRead) a_mr++;
         if (MemWrite) a_mw++;
         if (PCWrite) a_pcw++;
         if (PCWriteCond) a_pcc++;
         if (IRWrite) a_ir++;
         if (floating) a_fl++;
         if (illegal_op) a_ill++;
         if (fp_timeout) a_tmo++;
         if (fp_start) begin
            a_fps_n++;
            a_fps_at = a_lat;
         end
         if (instr_done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: instr_done with no instruction pending, state=%0d", state);
            end else begin
               e = exp_q.pop_front();
               check("latency", a_lat, e.lat);
               check("done_state", int'(state), e.done_st);
               check("illegal_op", a_ill, e.illegal);
               check("fp_timeout", a_tmo, e.tmo);
               check("regwrite_cycles", a_rw, e.regwrite);
               check("memtoreg_cycles", a_m2r, e.memtoreg);
               check("memread_cycles", a_mr, e.memread);
               check("memwrite_cycles", a_mw, e.memwrite);
               check("pcwrite_cycles", a_pcw, e.pcwrite);
               check("pcwritecond_cycles", a_pcc, e.pccond);
               check("irwrite_cycles", a_ir, e.irwrite);
               check("fp_start_count", a_fps_n, e.fpstart_n);
               check("fp_start_cycle", a_fps_at, e.fpstart_at);
               check("floating_cycles", a_fl, e.floating);
            end
            clear_acc();
         end
      end
   end

   // Drives one instruction from its first FETCH cycle; w_f / w_d are the
   // mem_ready=0 cycles in FETCH and in the data access, k is the FPEXEC
   // cycle carrying fp_done (0 = never). zv<0 randomizes zero.
   task automatic run_instr(input logic [5:0] op, input int w_f, input int w_d,
                            input int k, input int zv);
      exp_t e;
      bit   mr[$];
      bit   fd[$];
      int   lat;
      int   n;
      int   s;
      bit   fp_ok;
      e = '{default: 0};
      e.memread = w_f + 1;
      e.pcwrite = 1;
      e.irwrite = 1;
      fp_ok = 1'b0;
      n = 0;
      case (op)
         OP_RTYPE: begin lat = w_f + 4; e.done_st = int'(RWB); e.regwrite = 1; end
         OP_ADDI:  begin lat = w_f + 4; e.done_st = int'(ADDIWB); e.regwrite = 1; end
         OP_LW: begin
            lat = w_f + w_d + 5; e.done_st = int'(MEMWB);
            e.regwrite = 1; e.memtoreg = 1; e.memread += w_d + 1;
         end
         OP_SW: begin lat = w_f + w_d + 4; e.done_st = int'(MEMWR); e.memwrite = w_d + 1; end
         OP_BEQ: begin lat = w_f + 3; e.done_st = int'(BRANCH); e.pccond = 1; end
         OP_J:   begin lat = w_f + 3; e.done_st = int'(JUMP); e.pcwrite = 2; end
         OP_FP: begin
            fp_ok = (k >= 1) && (k <= T);
            n = fp_ok ? k : T;
            lat = w_f + 2 + n + int'(fp_ok);
            e.done_st = fp_ok ? int'(FPWB) : int'(FPEXEC);
            e.regwrite = int'(fp_ok);
            e.tmo = int'(!fp_ok);
            e.fpstart_n = 1;
            e.fpstart_at = w_f + 3;
            e.floating = n + int'(fp_ok);
         end
         default: begin lat = w_f + 2; e.done_st = int'(DECODE); e.illegal = 1; end
      endcase
      e.lat = lat;
      exp_q.push_back(e);
      n_issued++;
      // Unsampled cycles carry random handshake values.
      for (int i = 0; i < lat; i++) begin
         mr.push_back(1'($urandom_range(0, 1)));
         fd.push_back(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < w_f; i++) mr[i] = 1'b0;
      mr[w_f] = 1'b1;
      if (op == OP_LW || op == OP_SW) begin
         s = w_f + 3;
         for (int i = 0; i < w_d; i++) mr[s + i] = 1'b0;
         mr[s + w_d] = 1'b1;
      end
      if (op == OP_FP) begin
         s = w_f + 2;
         for (int i = 0; i < n; i++) fd[s + i] = 1'b0;
         if (fp_ok) fd[s + n - 1] = 1'b1;
      end
      for (int i = 0; i < lat; i++) begin
         opcode    = op;
         mem_ready = mr[i];
         fp_done   = fd[i];
         zero      = (zv < 0) ? 1'($urandom_range(0, 1)) : 1'(zv);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      clear_acc();
      // Reset: outputs are the FETCH decode, IRWrite/PCWrite follow mem_ready.
      mem_ready = 1'b0;
      #2;
      check("reset_state", int'(state), int'(FETCH));
      check("reset_memread", int'(MemRead), 1);
      check("reset_alusrcb", int'(ALUSrcB), int'(SRCB_FOUR));
      check("reset_irwrite_mr0", int'(IRWrite), 0);
      check("reset_pcwrite_mr0", int'(PCWrite), 0);
      check("reset_others", int'({MemWrite, RegWrite, IorD, MemtoReg, RegDst, ALUSrcA,
                                  PCWriteCond, floating, fp_start, illegal_op,
                                  fp_timeout, instr_done, ALUOp, PCSource}), 0);
      mem_ready = 1'b1;
      #1;
      check("reset_irwrite_mr1", int'(IRWrite), 1);
      check("reset_pcwrite_mr1", int'(PCWrite), 1);
      check("reset_state_held", int'(state), int'(FETCH));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr(OP_LW, 0, 0, 0, -1);
      run_instr(OP_LW, 0, 2, 0, -1);
      run_instr(OP_BEQ, 0, 0, 0, 1);
      run_instr(OP_BEQ, 0, 0, 0, 0);
      run_instr(OP_FP, 0, 0, 3, -1);
      run_instr(OP_FP, 0, 0, 0, -1);
      run_instr(OP_FP, 1, 0, T, -1);
      run_instr(6'b111111, 0, 0, 0, -1);
      run_instr(OP_SW, 1, 1, 0, -1);
      run_instr(OP_J, 0, 0, 0, -1);
      run_instr(OP_RTYPE, 2, 0, 0, -1);
      run_instr(OP_ADDI, 0, 0, 0, -1);
      run_instr(OP_FP, 0, 0, 1, -1);

      for (int i = 0; i < 60; i++) begin
         logic [5:0] op;
         op = ops[$urandom_range(0, 7)];
         if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 8), -1);
      end

      // Reset in the middle of a stalled store: abandoned without completion.
      opcode = OP_SW;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_state", int'(state), int'(MEMWR));
      check("pre_reset_memwrite", int'(MemWrite), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_state", int'(state), int'(FETCH));
      check("midreset_memwrite", int'(MemWrite), 0);
      check("midreset_done", int'(instr_done), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_instr(OP_ADDI, 0, 0, 0, -1);
      run_instr(OP_LW, 1, 1, 0, -1);

      check("queue_empty", exp_q.size(), 0);
      check("done_count", n_done, n_issued);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
